noc_mm_ctrl_regs: RTL and testbench
===================================

# noc_mm_ctrl_regs

AXI4-Lite control/status register block that sits directly upstream of `noc_mm_wrapper`. It replaces the VIO drive of `start`, `M1`/`M2`/`M3` and `addr_matrix_a/b/d`. Software on CIPS programs sizes and DDR addresses, issues a start, then polls or takes an interrupt on done/error. The block also counts the cycles of each run.

## Interface
Parameters:
- `MATRIXSIZE_W`, 24, width of the M1/M2/M3 outputs.
- `AXI_ADDR_WIDTH`, 64, width of the matrix base-address outputs.
- `S_ADDR_W`, 8, AXI-Lite address width; byte address, 32-bit data.

Ports (clock and reset first):
- `clk_pl`  in  1  sole clock.
- `rstn_pl`  in  1  reset; asynchronous assert, active-low.
- `s_axil_awaddr`  in  S_ADDR_W; `s_axil_awvalid` in 1; `s_axil_awready` out 1.
- `s_axil_wdata`  in  32; `s_axil_wstrb` in 4; `s_axil_wvalid` in 1; `s_axil_wready` out 1.
- `s_axil_bresp`  out  2; `s_axil_bvalid` out 1; `s_axil_bready` in 1.
- `s_axil_araddr`  in  S_ADDR_W; `s_axil_arvalid` in 1; `s_axil_arready` out 1.
- `s_axil_rdata`  out  32; `s_axil_rresp` out 2; `s_axil_rvalid` out 1; `s_axil_rready` in 1.
- `mm_start`  out  1  one-cycle start pulse to the wrapper's `start`.
- `mm_done` / `mm_error`  in  1  from the wrapper's `done` / `error`.
- `M1`, `M2`, `M3`  out  MATRIXSIZE_W  matrix dimensions.
- `addr_matrix_a/b/d`  out  AXI_ADDR_WIDTH  DDR base addresses.
- `irq`  out  1  level interrupt.

## Operation
Register map (word offsets). Reads of write-only bits return 0.
- 0x00 CTRL:
  - bit0 START: write 1 to start; self-clearing.
  - bit1 CLR: write 1 to clear DONE and ERROR.
  - bit2 IE: read/write interrupt enable.
- 0x04 STATUS (RO): bit0 BUSY, bit1 DONE (sticky), bit2 ERROR (sticky).
- 0x08/0x0C/0x10 M1/M2/M3 (RW): low MATRIXSIZE_W bits stored; upper bits read 0.
- 0x14/0x18 A_LO/A_HI, 0x1C/0x20 B_LO/B_HI, 0x24/0x28 D_LO/D_HI (RW). Only bits below AXI_ADDR_WIDTH are stored.
- 0x2C CYCLES (RO): 32-bit count of busy cycles for the current or last run; saturates at 0xFFFF_FFFF.

Write rules:
- `wstrb` byte lanes are honoured on all RW registers.
- START and CLR act only if `wstrb[0]` is set.
- START while BUSY is ignored and returns OKAY.
- Writes to 0x08–0x28 while BUSY are dropped and return SLVERR (2'b10). Configuration outputs stay constant for the whole run.
- Unmapped offsets (≥0x30 or unaligned): writes are ignored, reads return 0, and the response is SLVERR.

Run sequence:
- START accepted: BUSY goes to 1, CYCLES is cleared, and `mm_start` pulses.
- Each cycle with BUSY=1, CYCLES increments.
- First cycle with `mm_done`=1 and BUSY=1: BUSY goes to 0, DONE goes to 1, and ERROR |= `mm_error`.
- `mm_done` while idle is ignored.
- `irq` = IE & (DONE | ERROR), registered.

Simultaneous events:
- A done event and CLR in the same cycle: the done event wins, so DONE ends at 1.
- A STATUS read in the same cycle as a done event returns the pre-update value.

## Timing
- Reset values:
  - All outputs are 0, including every ready, valid, resp, data, config and `irq`.
  - `awready`, `wready` and `arready` rise on the first clock edge after `rstn_pl` deasserts.
- Write channel, one outstanding transaction:
  - AW and W may be accepted in either order or in the same cycle. Each ready drops once its beat has been captured.
  - The commit cycle is the cycle in which the second of AW/W is held. On the next edge: register update, `bvalid`=1, and `mm_start` pulses if START was accepted. `mm_start` lasts exactly one cycle.
  - `bvalid` holds until `bready`. `awready`/`wready` reassert the cycle after the B handshake.
- Read channel:
  - The AR handshake drops `arready`.
  - `rvalid`/`rdata`/`rresp` are registered on the next edge and held until `rready`.
  - `arready` reasserts the cycle after the R handshake.
  - Read and write channels operate independently.
- Done latency: `mm_done` sampled high → BUSY, DONE and ERROR update on the next edge → `irq` one edge later.
- Reset mid-operation:
  - BUSY and all sticky bits clear, and any in-flight AXI transaction is discarded without a response.
  - `noc_mm_top` shares `rstn_pl`.

## Structure
- Shared package `noc_mm_ctrl_pkg` holds:
  - register offsets;
  - CTRL/STATUS bit indices;
  - AXI response codes `RESP_OKAY`/`RESP_SLVERR`.
- One sub-module, `noc_mm_axil_if`, carries the AW/W/B/AR/R handshake FSMs. It presents a single-cycle `wr_en`/`wr_addr`/`wr_data`/`wr_strb` strobe and a `rd_en`/`rd_addr` strobe, and takes `wr_resp` and `rd_data`/`rd_resp` back.
- The top holds the register file, run control and cycle counter.

## Test plan
- **Reset:** hold `rstn_pl`=0 for 5 cycles, then release → every output is 0 during reset; `awready`, `wready` and `arready` are 1 one cycle after release; all registers read 0.
- **Configure and run:**
  - Stimulus: write M1=64, M2=128, M3=32, A=0x0000_0001_0000_0000; write CTRL=0x5; drive `mm_done` 100 cycles after `mm_start`.
  - Response: exactly one `mm_start` pulse, aligned with `bvalid`; outputs show the programmed values; STATUS=0x2; CYCLES=100; `irq`=1 two edges after `mm_done`.
- **Busy protection:** write M1=8 and CTRL=0x1 while BUSY → M1 write gets SLVERR, M1 output is unchanged, no second `mm_start`, and CTRL gets OKAY.
- **Error and clear:** `mm_done`=`mm_error`=1 → STATUS=0x6. Write CLR → STATUS=0x0 and `irq`=0. CLR in the same cycle as a done event → STATUS=0x2.
- **AXI ordering:** W beat 3 cycles before AW; `bready` held low 4 cycles; a read of 0x40 → the write commits correctly and `bvalid` is held; the read returns 0 with SLVERR.
- **Strobes:** write M2=0xAABBCCDD with `wstrb`=0x2 over an old value of 0 → readback 0x0000CC00.

Source files
------------

// File: rtl/noc_mm_ctrl_pkg.sv
// Shared definitions for the noc_mm control/status register block.
// Holds the register offsets, the CTRL/STATUS bit positions, the AXI
// response codes and a byte-lane merge helper used by every RW register.
package noc_mm_ctrl_pkg;

  // Byte offsets of the register map
  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_M1     = 8'h08;
  localparam logic [7:0] OFF_M3     = 8'h10;
  localparam logic [7:0] OFF_A_LO   = 8'h14;
  localparam logic [7:0] OFF_D_HI   = 8'h28;
  localparam logic [7:0] OFF_CYCLES = 8'h2C;
  localparam logic [7:0] OFF_END    = 8'h30;

  // CTRL bits
  localparam int CTRL_START = 0;
  localparam int CTRL_CLR   = 1;
  localparam int CTRL_IE    = 2;

  // STATUS bits
  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;
  localparam int STAT_ERROR = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Merge new_val into old_val on the byte lanes enabled in strb.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/noc_mm_axil_if.sv
// AXI4-Lite slave handshake engine.
// Captures AW and W independently (either order), then issues a one-cycle
// wr_en strobe once both are held; the response is latched into B on the
// same edge. A read handshake produces a one-cycle rd_en strobe and the
// returned data/response are registered into R.
// Ports: clk_pl/rstn_pl, the five AXI-Lite channels, and the register-side
// wr_en/wr_addr/wr_data/wr_strb/wr_resp and rd_en/rd_addr/rd_data/rd_resp.
module noc_mm_axil_if #(
  parameter int S_ADDR_W = 8
) (
  input  logic                clk_pl,
  input  logic                rstn_pl,
  input  logic [S_ADDR_W-1:0] s_axil_awaddr,
  input  logic                s_axil_awvalid,
  output logic                s_axil_awready,
  input  logic [31:0]         s_axil_wdata,
  input  logic [3:0]          s_axil_wstrb,
  input  logic                s_axil_wvalid,
  output logic                s_axil_wready,
  output logic [1:0]          s_axil_bresp,
  output logic                s_axil_bvalid,
  input  logic                s_axil_bready,
  input  logic [S_ADDR_W-1:0] s_axil_araddr,
  input  logic                s_axil_arvalid,
  output logic                s_axil_arready,
  output logic [31:0]         s_axil_rdata,
  output logic [1:0]          s_axil_rresp,
  output logic                s_axil_rvalid,
  input  logic                s_axil_rready,
  output logic                wr_en,
  output logic [S_ADDR_W-1:0] wr_addr,
  output logic [31:0]         wr_data,
  output logic [3:0]          wr_strb,
  input  logic [1:0]          wr_resp,
  output logic                rd_en,
  output logic [S_ADDR_W-1:0] rd_addr,
  input  logic [31:0]         rd_data,
  input  logic [1:0]          rd_resp
);

  logic                awready_q, awready_d, wready_q, wready_d;
  logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [S_ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic                bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic                arready_q, arready_d, rvalid_q, rvalid_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;
  logic                aw_hs, w_hs;

  always_comb begin
    aw_hs    = s_axil_awvalid & awready_q;
    w_hs     = s_axil_wvalid & wready_q;
    // Both beats held: this is the commit cycle
    wr_en    = aw_done_q & w_done_q;
    wr_addr  = awaddr_q;
    wr_data  = wdata_q;
    wr_strb  = wstrb_q;

    aw_done_d = wr_en ? 1'b0 : (aw_done_q | aw_hs);
    w_done_d  = wr_en ? 1'b0 : (w_done_q | w_hs);
    awaddr_d  = aw_hs ? s_axil_awaddr : awaddr_q;
    wdata_d   = w_hs ? s_axil_wdata : wdata_q;
    wstrb_d   = w_hs ? s_axil_wstrb : wstrb_q;
    bvalid_d  = wr_en | (bvalid_q & ~s_axil_bready);
    bresp_d   = wr_en ? wr_resp : bresp_q;
    // A channel is ready only when it holds no beat and no response is pending;
    // this also raises the readies on the first edge out of reset.
    awready_d = ~aw_done_d & ~bvalid_d;
    wready_d  = ~w_done_d & ~bvalid_d;

    rd_en     = s_axil_arvalid & arready_q;
    rd_addr   = s_axil_araddr;
    rvalid_d  = rd_en | (rvalid_q & ~s_axil_rready);
    rdata_d   = rd_en ? rd_data : rdata_q;
    rresp_d   = rd_en ? rd_resp : rresp_q;
    arready_d = ~rvalid_d;
  end

  always_ff @(posedge clk_pl or negedge rstn_pl) begin
    if (!rstn_pl) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      awready_q <= awready_d;
      wready_q  <= wready_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign s_axil_awready = awready_q;
  assign s_axil_wready  = wready_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_arready = arready_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;

endmodule

// File: rtl/noc_mm_ctrl_regs.sv
// Control/status registers for noc_mm_wrapper.
// Software programs M1/M2/M3 and the A/B/D DDR base addresses, writes START,
// then polls STATUS or waits for irq. The block counts busy cycles per run.
// Ports: clk_pl/rstn_pl, AXI4-Lite slave (s_axil_*), mm_start pulse out,
// mm_done/mm_error in, M1/M2/M3 and addr_matrix_a/b/d config out, irq out.
module noc_mm_ctrl_regs
  import noc_mm_ctrl_pkg::*;
#(
  parameter int MATRIXSIZE_W   = 24,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int S_ADDR_W       = 8
) (
  input  logic                      clk_pl,
  input  logic                      rstn_pl,
  input  logic [S_ADDR_W-1:0]       s_axil_awaddr,
  input  logic                      s_axil_awvalid,
  output logic                      s_axil_awready,
  input  logic [31:0]               s_axil_wdata,
  input  logic [3:0]                s_axil_wstrb,
  input  logic                      s_axil_wvalid,
  output logic                      s_axil_wready,
  output logic [1:0]                s_axil_bresp,
  output logic                      s_axil_bvalid,
  input  logic                      s_axil_bready,
  input  logic [S_ADDR_W-1:0]       s_axil_araddr,
  input  logic                      s_axil_arvalid,
  output logic                      s_axil_arready,
  output logic [31:0]               s_axil_rdata,
  output logic [1:0]                s_axil_rresp,
  output logic                      s_axil_rvalid,
  input  logic                      s_axil_rready,
  output logic                      mm_start,
  input  logic                      mm_done,
  input  logic                      mm_error,
  output logic [MATRIXSIZE_W-1:0]   M1,
  output logic [MATRIXSIZE_W-1:0]   M2,
  output logic [MATRIXSIZE_W-1:0]   M3,
  output logic [AXI_ADDR_WIDTH-1:0] addr_matrix_a,
  output logic [AXI_ADDR_WIDTH-1:0] addr_matrix_b,
  output logic [AXI_ADDR_WIDTH-1:0] addr_matrix_d,
  output logic                      irq
);

  logic                wr_en, rd_en;
  logic [S_ADDR_W-1:0] wr_addr, rd_addr;
  logic [31:0]         wr_data, rd_data;
  logic [3:0]          wr_strb;
  logic [1:0]          wr_resp, rd_resp;

  noc_mm_axil_if #(.S_ADDR_W(S_ADDR_W)) u_axil_if (
    .clk_pl         (clk_pl),
    .rstn_pl        (rstn_pl),
    .s_axil_awaddr  (s_axil_awaddr),
    .s_axil_awvalid (s_axil_awvalid),
    .s_axil_awready (s_axil_awready),
    .s_axil_wdata   (s_axil_wdata),
    .s_axil_wstrb   (s_axil_wstrb),
    .s_axil_wvalid  (s_axil_wvalid),
    .s_axil_wready  (s_axil_wready),
    .s_axil_bresp   (s_axil_bresp),
    .s_axil_bvalid  (s_axil_bvalid),
    .s_axil_bready  (s_axil_bready),
    .s_axil_araddr  (s_axil_araddr),
    .s_axil_arvalid (s_axil_arvalid),
    .s_axil_arready (s_axil_arready),
    .s_axil_rdata   (s_axil_rdata),
    .s_axil_rresp   (s_axil_rresp),
    .s_axil_rvalid  (s_axil_rvalid),
    .s_axil_rready  (s_axil_rready),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_strb        (wr_strb),
    .wr_resp        (wr_resp),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .rd_resp        (rd_resp)
  );

  // Index 0/1/2 = M1/M2/M3 and A/B/D respectively
  logic [MATRIXSIZE_W-1:0]   msz_q [3];
  logic [MATRIXSIZE_W-1:0]   msz_d [3];
  logic [AXI_ADDR_WIDTH-1:0] base_q [3];
  logic [AXI_ADDR_WIDTH-1:0] base_d [3];
  logic        ie_q, ie_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic        mm_start_q, mm_start_d, irq_q, irq_d;
  logic [31:0] cycles_q, cycles_d;
  logic        start_acc, clr, done_evt;
  logic [63:0] wr_base, rd_base;
  logic [7:0]  wr_off, rd_off;
  logic [1:0]  wr_m_idx, wr_b_idx, rd_m_idx, rd_b_idx;

  function automatic logic addr_mapped(input logic [S_ADDR_W-1:0] a);
    return (a[1:0] == 2'b00) && (a < S_ADDR_W'(OFF_END));
  endfunction

  // Base-address registers alternate LO/HI every 4 bytes starting at 0x14,
  // so LO has address bit 2 set and HI has it clear.
  assign wr_off   = wr_addr[7:0];
  assign rd_off   = rd_addr[7:0];
  assign wr_m_idx = 2'((wr_off - OFF_M1) >> 2);
  assign rd_m_idx = 2'((rd_off - OFF_M1) >> 2);
  assign wr_b_idx = 2'((wr_off - OFF_A_LO) >> 3);
  assign rd_b_idx = 2'((rd_off - OFF_A_LO) >> 3);

  // Register writes, CTRL side effects and run control
  always_comb begin
    msz_d     = msz_q;
    base_d    = base_q;
    ie_d      = ie_q;
    start_acc = 1'b0;
    clr       = 1'b0;
    wr_resp   = RESP_OKAY;
    wr_base   = 64'(base_q[wr_b_idx]);
    if (wr_en) begin
      if (!addr_mapped(wr_addr)) begin
        wr_resp = RESP_SLVERR;
      end else if (busy_q && wr_off >= OFF_M1 && wr_off <= OFF_D_HI) begin
        // Config is frozen for the whole run
        wr_resp = RESP_SLVERR;
      end else if (wr_off == OFF_CTRL) begin
        if (wr_strb[0]) begin
          ie_d      = wr_data[CTRL_IE];
          start_acc = wr_data[CTRL_START] & ~busy_q;
          clr       = wr_data[CTRL_CLR];
        end
      end else if (wr_off >= OFF_M1 && wr_off <= OFF_M3) begin
        msz_d[wr_m_idx] = MATRIXSIZE_W'(apply_strb(32'(msz_q[wr_m_idx]), wr_data, wr_strb));
      end else if (wr_off >= OFF_A_LO && wr_off <= OFF_D_HI) begin
        if (wr_off[2]) wr_base[31:0]  = apply_strb(wr_base[31:0], wr_data, wr_strb);
        else           wr_base[63:32] = apply_strb(wr_base[63:32], wr_data, wr_strb);
        base_d[wr_b_idx] = AXI_ADDR_WIDTH'(wr_base);
      end
    end

    done_evt   = busy_q & mm_done;
    busy_d     = start_acc | (busy_q & ~done_evt);
    // A done event overrides a coincident CLR
    done_d     = (done_q & ~clr) | done_evt;
    err_d      = (err_q & ~clr) | (done_evt & mm_error);
    mm_start_d = start_acc;
    irq_d      = ie_q & (done_q | err_q);
    cycles_d   = cycles_q;
    if (start_acc)                          cycles_d = '0;
    else if (busy_q && cycles_q != '1)      cycles_d = cycles_q + 32'd1;
  end

  // Read mux; reflects current register state, so a read coinciding with an
  // update returns the pre-update value.
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    rd_base = 64'(base_q[rd_b_idx]);
    if (!addr_mapped(rd_addr)) begin
      rd_resp = RESP_SLVERR;
    end else if (rd_off == OFF_CTRL) begin
      rd_data[CTRL_IE] = ie_q;
    end else if (rd_off == OFF_STATUS) begin
      rd_data[STAT_BUSY]  = busy_q;
      rd_data[STAT_DONE]  = done_q;
      rd_data[STAT_ERROR] = err_q;
    end else if (rd_off >= OFF_M1 && rd_off <= OFF_M3) begin
      rd_data = 32'(msz_q[rd_m_idx]);
    end else if (rd_off >= OFF_A_LO && rd_off <= OFF_D_HI) begin
      rd_data = rd_off[2] ? rd_base[31:0] : rd_base[63:32];
    end else if (rd_off == OFF_CYCLES) begin
      rd_data = cycles_q;
    end
  end

  always_ff @(posedge clk_pl or negedge rstn_pl) begin
    if (!rstn_pl) begin
      for (int i = 0; i < 3; i++) begin
        msz_q[i]  <= '0;
        base_q[i] <= '0;
      end
      ie_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      mm_start_q <= 1'b0;
      irq_q      <= 1'b0;
      cycles_q   <= '0;
    end else begin
      msz_q      <= msz_d;
      base_q     <= base_d;
      ie_q       <= ie_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      mm_start_q <= mm_start_d;
      irq_q      <= irq_d;
      cycles_q   <= cycles_d;
    end
  end

  assign mm_start      = mm_start_q;
  assign irq           = irq_q;
  assign M1            = msz_q[0];
  assign M2            = msz_q[1];
  assign M3            = msz_q[2];
  assign addr_matrix_a = base_q[0];
  assign addr_matrix_b = base_q[1];
  assign addr_matrix_d = base_q[2];

  // rd_en is implied by the registered R capture in the interface
  logic unused_rd_en;
  assign unused_rd_en = rd_en;

endmodule

// File: tb/tb_noc_mm_ctrl_regs.sv
module tb_noc_mm_ctrl_regs;

  logic        clk_pl = 1'b0;
  logic        rstn_pl = 1'b0;
  logic [7:0]  s_axil_awaddr = '0;
  logic        s_axil_awvalid = 1'b0;
  logic        s_axil_awready;
  logic [31:0] s_axil_wdata = '0;
  logic [3:0]  s_axil_wstrb = '0;
  logic        s_axil_wvalid = 1'b0;
  logic        s_axil_wready;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_bvalid;
  logic        s_axil_bready = 1'b0;
  logic [7:0]  s_axil_araddr = '0;
  logic        s_axil_arvalid = 1'b0;
  logic        s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid;
  logic        s_axil_rready = 1'b0;
  logic        mm_start;
  logic        mm_done = 1'b0;
  logic        mm_error = 1'b0;
  logic [23:0] M1, M2, M3;
  logic [63:0] addr_matrix_a, addr_matrix_b, addr_matrix_d;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  noc_mm_ctrl_regs #(.MATRIXSIZE_W(24), .AXI_ADDR_WIDTH(64), .S_ADDR_W(8)) dut (
    .clk_pl(clk_pl), .rstn_pl(rstn_pl),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
    .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp), .s_axil_rvalid(s_axil_rvalid),
    .s_axil_rready(s_axil_rready),
    .mm_start(mm_start), .mm_done(mm_done), .mm_error(mm_error),
    .M1(M1), .M2(M2), .M3(M3),
    .addr_matrix_a(addr_matrix_a), .addr_matrix_b(addr_matrix_b), .addr_matrix_d(addr_matrix_d),
    .irq(irq)
  );

  always #5 clk_pl = ~clk_pl;

  always @(posedge clk_pl) if (mm_start) start_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // All tasks are entered 1 time unit after a rising edge.
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp,
                           output logic start_seen);
    int n;
    logic aw_hs, w_hs;
    s_axil_awaddr = addr; s_axil_awvalid = 1'b1;
    s_axil_wdata = data; s_axil_wstrb = strb; s_axil_wvalid = 1'b1;
    n = 0;
    while ((s_axil_awvalid || s_axil_wvalid) && n < 20) begin
      aw_hs = s_axil_awvalid & s_axil_awready;
      w_hs  = s_axil_wvalid & s_axil_wready;
      @(posedge clk_pl); #1;
      if (aw_hs) s_axil_awvalid = 1'b0;
      if (w_hs)  s_axil_wvalid = 1'b0;
      n++;
    end
    n = 0;
    while (!s_axil_bvalid && n < 20) begin
      @(posedge clk_pl); #1;
      n++;
    end
    checks++;
    if (!s_axil_bvalid) begin
      errors++;
      $display("FAIL wr_timeout addr=%02h: bvalid=0 required 1", addr);
      s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
      resp = 2'b11; start_seen = 1'b0;
      return;
    end
    resp = s_axil_bresp;
    start_seen = mm_start;
    s_axil_bready = 1'b1;
    @(posedge clk_pl); #1;
    s_axil_bready = 1'b0;
    $display("TB write addr=%02h data=%08h strb=%h resp=%0d start=%0b", addr, data, strb, resp, start_seen);
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    logic hs;
    s_axil_araddr = addr; s_axil_arvalid = 1'b1;
    n = 0;
    while (s_axil_arvalid && n < 20) begin
      hs = s_axil_arready;
      @(posedge clk_pl); #1;
      if (hs) s_axil_arvalid = 1'b0;
      n++;
    end
    n = 0;
    while (!s_axil_rvalid && n < 20) begin
      @(posedge clk_pl); #1;
      n++;
    end
    checks++;
    if (!s_axil_rvalid) begin
      errors++;
      $display("FAIL rd_timeout addr=%02h: rvalid=0 required 1", addr);
      s_axil_arvalid = 1'b0;
      data = '1; resp = 2'b11;
      return;
    end
    data = s_axil_rdata; resp = s_axil_rresp;
    s_axil_rready = 1'b1;
    @(posedge clk_pl); #1;
    s_axil_rready = 1'b0;
    $display("TB read addr=%02h data=%08h resp=%0d", addr, data, resp);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  r;
    repeat (5) @(posedge clk_pl);
    #1;
    checks++;
    if ({s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_bresp, s_axil_arready, s_axil_rvalid,
         s_axil_rdata, s_axil_rresp, mm_start, M1, M2, M3, addr_matrix_a, addr_matrix_b,
         addr_matrix_d, irq} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: some output nonzero during reset, required all 0");
    end
    @(negedge clk_pl);
    rstn_pl = 1'b1;
    #1;
    checks++;
    if ({s_axil_awready, s_axil_wready, s_axil_arready} !== 3'b000) begin
      errors++;
      $display("FAIL ready_before_edge: got %b required 000",
               {s_axil_awready, s_axil_wready, s_axil_arready});
    end
    @(posedge clk_pl); #1;
    checks++;
    if ({s_axil_awready, s_axil_wready, s_axil_arready} !== 3'b111) begin
      errors++;
      $display("FAIL ready_after_release: got %b required 111",
               {s_axil_awready, s_axil_wready, s_axil_arready});
    end
    for (int i = 0; i < 12; i++) begin
      axi_read(8'(i * 4), d, r);
      checks++;
      if (d !== 32'h0 || r !== 2'b00) begin
        errors++;
        $display("FAIL reset_reg_%02h: got data=%08h resp=%0d required 00000000 resp=0", i * 4, d, r);
      end
    end
  endtask

  task automatic test_config_run();
    logic [31:0] d;
    logic [1:0]  r, racc;
    logic        ss;
    int          s0;
    racc = 2'b00;
    axi_write(8'h08, 32'd64,  4'hF, r, ss); racc |= r;
    axi_write(8'h0C, 32'd128, 4'hF, r, ss); racc |= r;
    axi_write(8'h10, 32'd32,  4'hF, r, ss); racc |= r;
    axi_write(8'h14, 32'h0,   4'hF, r, ss); racc |= r;
    axi_write(8'h18, 32'h1,   4'hF, r, ss); racc |= r;
    checks++;
    if (racc !== 2'b00) begin
      errors++; $display("FAIL cfg_resp: got %0d required 0", racc);
    end
    s0 = start_cnt;
    axi_write(8'h00, 32'h5, 4'hF, r, ss);
    checks++;
    if (ss !== 1'b1 || r !== 2'b00) begin
      errors++; $display("FAIL start_align: mm_start=%0b resp=%0d required 1 resp=0", ss, r);
    end
    // mm_start was high in cycle C0; now in C1. Assert mm_done in cycle C99.
    repeat (98) @(posedge clk_pl);
    #1; mm_done = 1'b1;
    @(posedge clk_pl); #1; mm_done = 1'b0;
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL irq_early: got %0b required 0", irq);
    end
    @(posedge clk_pl); #1;
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL irq_two_edges: got %0b required 1", irq);
    end
    checks++;
    if (start_cnt - s0 !== 1) begin
      errors++; $display("FAIL start_count: got %0d required 1", start_cnt - s0);
    end
    checks++;
    if (M1 !== 24'd64 || M2 !== 24'd128 || M3 !== 24'd32 || addr_matrix_a !== 64'h0000_0001_0000_0000) begin
      errors++;
      $display("FAIL cfg_outputs: got M1=%0d M2=%0d M3=%0d A=%016h required 64 128 32 0000000100000000",
               M1, M2, M3, addr_matrix_a);
    end
    axi_read(8'h04, d, r);
    checks++;
    if (d !== 32'h2) begin
      errors++; $display("FAIL status_done: got %08h required 00000002", d);
    end
    axi_read(8'h2C, d, r);
    checks++;
    if (d !== 32'd100) begin
      errors++; $display("FAIL cycles: got %0d required 100", d);
    end
  endtask

  task automatic test_busy_protect();
    logic [31:0] d;
    logic [1:0]  r;
    logic        ss;
    int          s0;
    axi_write(8'h00, 32'h1, 4'hF, r, ss);
    checks++;
    if (ss !== 1'b1) begin
      errors++; $display("FAIL run2_start: got %0b required 1", ss);
    end
    s0 = start_cnt;
    axi_write(8'h08, 32'd8, 4'hF, r, ss);
    checks++;
    if (r !== 2'b10) begin
      errors++; $display("FAIL busy_cfg_resp: got %0d required 2", r);
    end
    checks++;
    if (M1 !== 24'd64) begin
      errors++; $display("FAIL busy_m1_hold: got %0d required 64", M1);
    end
    axi_write(8'h00, 32'h1, 4'hF, r, ss);
    checks++;
    if (r !== 2'b00 || ss !== 1'b0) begin
      errors++; $display("FAIL busy_start: resp=%0d start=%0b required resp=0 start=0", r, ss);
    end
    axi_read(8'h04, d, r);
    checks++;
    if (d !== 32'h3 || start_cnt !== s0) begin
      errors++;
      $display("FAIL busy_status: got %08h extra_starts=%0d required 00000003 extra_starts=0", d, start_cnt - s0);
    end
  endtask

  task automatic test_error_clear();
    logic [31:0] d;
    logic [1:0]  r;
    logic        ss;
    axi_write(8'h00, 32'h4, 4'hF, r, ss);   // IE on while run still busy
    mm_done = 1'b1; mm_error = 1'b1;
    @(posedge clk_pl); #1; mm_done = 1'b0; mm_error = 1'b0;
    @(posedge clk_pl); #1;
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL err_irq: got %0b required 1", irq);
    end
    axi_read(8'h04, d, r);
    checks++;
    if (d !== 32'h6) begin
      errors++; $display("FAIL status_err: got %08h required 00000006", d);
    end
    axi_write(8'h00, 32'h6, 4'hF, r, ss);
    axi_read(8'h04, d, r);
    checks++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      errors++; $display("FAIL clear: status=%08h irq=%0b required 00000000 irq=0", d, irq);
    end
    // New run, then CLR committed in the same cycle as the done event
    axi_write(8'h00, 32'h5, 4'hF, r, ss);
    s_axil_awaddr = 8'h00; s_axil_awvalid = 1'b1;
    s_axil_wdata = 32'h6; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
    @(posedge clk_pl); #1;
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    mm_done = 1'b1;
    @(posedge clk_pl); #1;
    mm_done = 1'b0;
    checks++;
    if (s_axil_bvalid !== 1'b1 || s_axil_bresp !== 2'b00) begin
      errors++; $display("FAIL clr_done_b: bvalid=%0b resp=%0d required 1 resp=0", s_axil_bvalid, s_axil_bresp);
    end
    s_axil_bready = 1'b1;
    @(posedge clk_pl); #1;
    s_axil_bready = 1'b0;
    $display("TB write addr=00 data=00000006 strb=f (CLR with done)");
    axi_read(8'h04, d, r);
    checks++;
    if (d !== 32'h2) begin
      errors++; $display("FAIL clr_vs_done: got %08h required 00000002", d);
    end
  endtask

  task automatic test_axi_order();
    s_axil_wdata = 32'h55; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
    s_axil_araddr = 8'h40; s_axil_arvalid = 1'b1;
    @(posedge clk_pl); #1;
    s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
    checks++;
    if (s_axil_wready !== 1'b0 || s_axil_awready !== 1'b1) begin
      errors++; $display("FAIL w_first_ready: wready=%0b awready=%0b required 0 1", s_axil_wready, s_axil_awready);
    end
    checks++;
    if (s_axil_rvalid !== 1'b1 || s_axil_rdata !== 32'h0 || s_axil_rresp !== 2'b10) begin
      errors++;
      $display("FAIL unmapped_read: rvalid=%0b data=%08h resp=%0d required 1 00000000 2",
               s_axil_rvalid, s_axil_rdata, s_axil_rresp);
    end
    @(posedge clk_pl); #1;
    @(posedge clk_pl); #1;
    s_axil_awaddr = 8'h10; s_axil_awvalid = 1'b1; s_axil_rready = 1'b1;
    @(posedge clk_pl); #1;
    s_axil_awvalid = 1'b0; s_axil_rready = 1'b0;
    $display("TB read addr=40 (concurrent)");
    @(posedge clk_pl); #1;
    checks++;
    if (s_axil_bvalid !== 1'b1 || s_axil_bresp !== 2'b00) begin
      errors++; $display("FAIL late_aw_commit: bvalid=%0b resp=%0d required 1 resp=0", s_axil_bvalid, s_axil_bresp);
    end
    repeat (4) begin
      @(posedge clk_pl); #1;
    end
    checks++;
    if (s_axil_bvalid !== 1'b1 || M3 !== 24'h55) begin
      errors++; $display("FAIL b_hold: bvalid=%0b M3=%06h required 1 000055", s_axil_bvalid, M3);
    end
    s_axil_bready = 1'b1;
    @(posedge clk_pl); #1;
    s_axil_bready = 1'b0;
    $display("TB write addr=10 data=00000055 strb=f (W before AW)");
    checks++;
    if ({s_axil_bvalid, s_axil_awready, s_axil_wready, s_axil_arready} !== 4'b0111) begin
      errors++;
      $display("FAIL ready_reassert: got %b required 0111",
               {s_axil_bvalid, s_axil_awready, s_axil_wready, s_axil_arready});
    end
  endtask

  task automatic test_strobes();
    logic [31:0] d;
    logic [1:0]  r;
    logic        ss;
    axi_write(8'h0C, 32'h0, 4'hF, r, ss);
    axi_write(8'h0C, 32'hAABB_CCDD, 4'h2, r, ss);
    axi_read(8'h0C, d, r);
    checks++;
    if (d !== 32'h0000_CC00 || M2 !== 24'h00CC00) begin
      errors++; $display("FAIL strobe_m2: got %08h out=%06h required 0000cc00 00cc00", d, M2);
    end
    axi_write(8'h08, 32'hFFFF_FFFF, 4'hF, r, ss);
    axi_read(8'h08, d, r);
    checks++;
    if (d !== 32'h00FF_FFFF) begin
      errors++; $display("FAIL m1_width: got %08h required 00ffffff", d);
    end
    axi_write(8'h1D, 32'h1234_5678, 4'hF, r, ss);
    checks++;
    if (r !== 2'b10 || addr_matrix_b !== 64'h0) begin
      errors++; $display("FAIL unaligned_wr: resp=%0d B=%016h required 2 0", r, addr_matrix_b);
    end
    axi_write(8'h28, 32'hDEAD_BEEF, 4'hF, r, ss);
    axi_read(8'h28, d, r);
    checks++;
    if (d !== 32'hDEAD_BEEF || addr_matrix_d !== 64'hDEAD_BEEF_0000_0000) begin
      errors++; $display("FAIL d_hi: got %08h D=%016h required deadbeef deadbeef00000000", d, addr_matrix_d);
    end
    axi_read(8'h30, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b10) begin
      errors++; $display("FAIL read_30: got %08h resp=%0d required 00000000 resp=2", d, r);
    end
  endtask

  initial begin
    test_reset();
    test_config_run();
    test_busy_protect();
    test_error_clear();
    test_axi_order();
    test_strobes();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
